// File: rtl/cvae_pkg.sv
// Shared definitions for the CVAE datapath blocks.
//  - fc_state_t : fully-connected engine controller states
//  - fc_tag_t   : per-element tag travelling alongside the SRAM read latency
//  - round_shift / sat_clip : fixed-point requantisation helpers, evaluated
//    on a wide signed carrier (SAT_W bits) so callers can sign-extend into it
package cvae_pkg;

  localparam int unsigned FRAC_BITS_DEF = 24;
  localparam int unsigned RD_LAT_DEF    = 2;
  localparam int unsigned SAT_W         = 96;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_ZERO,
    ST_FIN
  } fc_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic fin;
  } fc_tag_t;

  // Round-half-up then arithmetic shift right by frac (frac >= 1).
  function automatic logic signed [SAT_W-1:0] round_shift(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             frac
  );
    logic signed [SAT_W-1:0] half;
    half = SAT_W'(1) << (frac - 1);
    return (v + half) >>> frac;
  endfunction

  // Clamp v to the signed range of a dw-bit word.
  function automatic logic signed [SAT_W-1:0] sat_clip(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Requantisation stage of the FC engine: round/shift the accumulator, add the
// bias, saturate to DATA_WIDTH and optionally apply ReLU, then register the
// result together with the output write strobe.
// Ports:
//  clk, rst_n : clock, async active-low reset
//  load       : final accumulation of a neuron is present on acc this cycle
//  acc        : signed accumulator value (ACC_WIDTH)
//  bias       : signed bias for this neuron (already 0 when bias is disabled)
//  relu_en    : clamp negative results to zero
//  wea        : registered write strobe (one cycle per load)
//  wdata      : registered result, held between writes
module fc_requant
  import cvae_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 76,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  relu_en,
  output logic                  wea,
  output logic [DATA_WIDTH-1:0] wdata
);

  logic signed [SAT_W-1:0] acc_w;
  logic signed [SAT_W-1:0] bias_w;
  logic signed [SAT_W-1:0] sum;
  logic [DATA_WIDTH-1:0]   result;

  always_comb begin
    acc_w  = {{(SAT_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    bias_w = {{(SAT_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    sum    = round_shift(acc_w, FRAC_BITS) + bias_w;
    result = DATA_WIDTH'(sat_clip(sum, DATA_WIDTH));
    // Saturation preserves sign, so the pre-clip sign decides ReLU.
    if (relu_en && sum[SAT_W-1]) result = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wea   <= 1'b0;
      wdata <= '0;
    end else begin
      wea <= load;
      if (load) wdata <= result;
    end
  end

endmodule

// File: rtl/fc_engine.sv
// Fully-connected layer engine: out[j] = act(sat(rnd(sum_k in[k]*W[j*IN+k]) + bias[j])).
// One MAC per cycle; addresses are issued back-to-back across rows and the
// returning SRAM data is matched up by a RD_LAT-deep tag pipeline.
// Ports:
//  clk, rst_n                : clock, async active-low reset
//  start / busy / done       : launch pulse (IDLE only), activity flag, completion pulse
//  cfg_*                     : dimensions, base addresses, bias/ReLU enables (sampled with start)
//  sram_input_*              : input vector SRAM read port
//  sram_weight_*             : weight SRAM read port (row-major, row = output neuron)
//  sram_bias_*               : bias SRAM read port
//  sram_output_*             : output SRAM write port
module fc_engine
  import cvae_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIM_WIDTH  = 12,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned ACC_WIDTH  = 76
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [DIM_WIDTH-1:0]  cfg_in_dim,
  input  logic [DIM_WIDTH-1:0]  cfg_out_dim,
  input  logic [ADDR_WIDTH-1:0] cfg_in_base,
  input  logic [ADDR_WIDTH-1:0] cfg_w_base,
  input  logic [ADDR_WIDTH-1:0] cfg_b_base,
  input  logic [ADDR_WIDTH-1:0] cfg_out_base,
  input  logic                  cfg_bias_en,
  input  logic                  cfg_relu_en,
  output logic [ADDR_WIDTH-1:0] sram_input_addr,
  input  logic [DATA_WIDTH-1:0] sram_input_rdata,
  output logic [ADDR_WIDTH-1:0] sram_weight_addr,
  input  logic [DATA_WIDTH-1:0] sram_weight_rdata,
  output logic [ADDR_WIDTH-1:0] sram_bias_addr,
  input  logic [DATA_WIDTH-1:0] sram_bias_rdata,
  output logic                  sram_output_wea,
  output logic [ADDR_WIDTH-1:0] sram_output_addr,
  output logic [DATA_WIDTH-1:0] sram_output_wdata
);

  if (ACC_WIDTH < 2*DATA_WIDTH + DIM_WIDTH) begin : g_chk_acc
    $error("fc_engine: ACC_WIDTH too small for 2*DATA_WIDTH+DIM_WIDTH");
  end
  if (ACC_WIDTH + 2 > SAT_W) begin : g_chk_sat
    $error("fc_engine: ACC_WIDTH exceeds requantisation carrier width");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_lat
    $error("fc_engine: RD_LAT must be 1..4");
  end
  if (FRAC_BITS < 1) begin : g_chk_frac
    $error("fc_engine: FRAC_BITS must be at least 1");
  end

  fc_state_t state_q, state_d;

  logic [DIM_WIDTH-1:0]  in_dim_q, out_dim_q;
  logic [ADDR_WIDTH-1:0] in_base_q;
  logic                  bias_en_q, relu_en_q;
  logic [DIM_WIDTH-1:0]  k_q, j_q;
  logic [ADDR_WIDTH-1:0] out_ptr_q;
  logic                  k_last, j_last, start_go, dims_ok;

  fc_tag_t               tag_in, tag_out;
  fc_tag_t [RD_LAT-1:0]  tag_pipe;
  fc_tag_t [RD_LAT-1:0]  pipe_d;

  logic [2*DATA_WIDTH-1:0] in_ext, w_ext, prod;
  logic [ACC_WIDTH-1:0]    prod_ext, acc_q, acc_sum;
  logic [DATA_WIDTH-1:0]   bias_q, bias_cur;
  logic                    last_wr_q;

  assign k_last   = (k_q == in_dim_q - DIM_WIDTH'(1));
  assign j_last   = (j_q == out_dim_q - DIM_WIDTH'(1));
  assign start_go = (state_q == ST_IDLE) && start;
  assign dims_ok  = (cfg_in_dim != '0) && (cfg_out_dim != '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = dims_ok ? ST_ISSUE : ST_ZERO;
      ST_ISSUE: begin
        busy = 1'b1;
        if (k_last && j_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (last_wr_q) state_d = ST_FIN;
      end
      ST_ZERO: begin
        busy    = 1'b1;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- address generation
  // Weight address is a running pointer: rows are contiguous, so it simply
  // increments every issue cycle without a j*IN multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_dim_q         <= '0;
      out_dim_q        <= '0;
      in_base_q        <= '0;
      bias_en_q        <= 1'b0;
      relu_en_q        <= 1'b0;
      k_q              <= '0;
      j_q              <= '0;
      sram_input_addr  <= '0;
      sram_weight_addr <= '0;
      sram_bias_addr   <= '0;
    end else if (start_go) begin
      in_dim_q  <= cfg_in_dim;
      out_dim_q <= cfg_out_dim;
      in_base_q <= cfg_in_base;
      bias_en_q <= cfg_bias_en;
      relu_en_q <= cfg_relu_en;
      k_q       <= '0;
      j_q       <= '0;
      if (dims_ok) begin
        sram_input_addr  <= cfg_in_base;
        sram_weight_addr <= cfg_w_base;
        sram_bias_addr   <= cfg_bias_en ? cfg_b_base : '0;
      end
    end else if (state_q == ST_ISSUE && !(k_last && j_last)) begin
      sram_weight_addr <= sram_weight_addr + ADDR_WIDTH'(1);
      if (k_last) begin
        k_q             <= '0;
        j_q             <= j_q + DIM_WIDTH'(1);
        sram_input_addr <= in_base_q;
        if (bias_en_q) sram_bias_addr <= sram_bias_addr + ADDR_WIDTH'(1);
      end else begin
        k_q             <= k_q + DIM_WIDTH'(1);
        sram_input_addr <= sram_input_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // ------------------------------------------------------ tag pipeline
  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state_q == ST_ISSUE);
    tag_in.first = (state_q == ST_ISSUE) && (k_q == '0);
    tag_in.last  = (state_q == ST_ISSUE) && k_last;
    tag_in.fin   = (state_q == ST_ISSUE) && k_last && j_last;
  end

  if (RD_LAT == 1) begin : g_lat1
    assign pipe_d = tag_in;
  end else begin : g_latn
    assign pipe_d = {tag_pipe[RD_LAT-2:0], tag_in};
  end

  assign tag_out = tag_pipe[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_pipe <= '0;
    else        tag_pipe <= pipe_d;
  end

  // ------------------------------------------------------- MAC datapath
  always_comb begin
    in_ext   = {{DATA_WIDTH{sram_input_rdata[DATA_WIDTH-1]}}, sram_input_rdata};
    w_ext    = {{DATA_WIDTH{sram_weight_rdata[DATA_WIDTH-1]}}, sram_weight_rdata};
    prod     = in_ext * w_ext;
    prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    // The first element of a row loads rather than adds, so no clear cycle
    // is needed between rows (IN=1 rows arrive every cycle).
    acc_sum  = tag_out.first ? prod_ext : acc_q + prod_ext;
    // Bias returns with the first element; for IN=1 it is used the same cycle.
    if (tag_out.first) bias_cur = bias_en_q ? sram_bias_rdata : '0;
    else               bias_cur = bias_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q            <= '0;
      bias_q           <= '0;
      out_ptr_q        <= '0;
      sram_output_addr <= '0;
      last_wr_q        <= 1'b0;
    end else begin
      last_wr_q <= tag_out.valid && tag_out.last && tag_out.fin;
      if (start_go) out_ptr_q <= cfg_out_base;
      if (tag_out.valid) begin
        acc_q <= acc_sum;
        if (tag_out.first) bias_q <= bias_cur;
        if (tag_out.last) begin
          sram_output_addr <= out_ptr_q;
          out_ptr_q        <= out_ptr_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  fc_requant #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_requant (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tag_out.valid && tag_out.last),
    .acc     (acc_sum),
    .bias    (bias_cur),
    .relu_en (relu_en_q),
    .wea     (sram_output_wea),
    .wdata   (sram_output_wdata)
  );

endmodule
